// File: rtl/apb_master_bridge.sv
// apb_master_bridge: APB3/APB4 requester fed by a valid/ready command stream,
// returning read data and slave error on a valid/ready response stream.
// At most one transfer is in flight. FSM: IDLE -> SETUP -> ACCESS -> IDLE.
// Optional feature macro: APB_MASTER_TIMEOUT_EN aborts an ACCESS phase after
// TIMEOUT_CYCLES stalled cycles and reports it as an error response.
// Handshake rule (cmd and rsp alike): a beat transfers on the rising PCLK edge
// where valid && ready are both 1; the producer keeps valid and payload stable
// until that edge, and the consumer may drive ready independently of valid.
module apb_master_bridge #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic                    PWRITE,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR,
  output logic [1:0]              dbg_state_o
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic                    run_q;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic                    pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic [STRB_WIDTH-1:0]   pstrb_q, pstrb_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    cmd_fire;
  logic                    xfer_done;
  logic                    timeout_hit;

  assign cmd_fire  = cmd_valid && cmd_ready;
  assign xfer_done = (state_q == ST_ACCESS) && PREADY;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                  $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  // Abort on the stalled ACCESS edge that would make the count reach TIMEOUT_CYCLES.
  assign timeout_hit = (state_q == ST_ACCESS) && !PREADY && (wait_cnt_q == CNT_LAST);

  // Stalled-ACCESS counter, cleared as a new transfer enters SETUP.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (cmd_fire) begin
      wait_cnt_d = '0;
    end else if ((state_q == ST_ACCESS) && !PREADY) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // FSM state register plus all datapath/response registers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= ST_IDLE;
      run_q       <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= 1'b1;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Next-state logic: SETUP always lasts one cycle, ACCESS waits for PREADY or timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (cmd_fire) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (xfer_done || timeout_hit) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // APB address/data capture on command acceptance; reads carry zero data and strobes.
  always_comb begin
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    if (cmd_fire) begin
      paddr_d  = cmd_addr;
      pwrite_d = cmd_write;
      pwdata_d = cmd_write ? cmd_wdata : '0;
      pstrb_d  = cmd_write ? cmd_strb : '0;
    end
  end

  // Response capture on completion/abort, held until consumed.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (xfer_done) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = pwrite_q ? '0 : PRDATA;
      rsp_err_d   = PSLVERR;
    end else if (timeout_hit) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = '0;
      rsp_err_d   = 1'b1;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // FSM outputs: PSEL/PENABLE decode straight from state so reset drops them at once.
  always_comb begin
    PSEL      = (state_q != ST_IDLE);
    PENABLE   = (state_q == ST_ACCESS);
    cmd_ready = run_q && (state_q == ST_IDLE) && !rsp_valid_q;
  end

  assign PADDR       = paddr_q;
  assign PWRITE      = pwrite_q;
  assign PWDATA      = pwdata_q;
  assign PSTRB       = pstrb_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed table, hand-written corner sequences and a
// randomized stream for apb_master_bridge. The bench plays the APB slave.
module tb_apb_master_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_strb;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] PADDR;
  logic          PWRITE, PSEL, PENABLE;
  logic [DW-1:0] PWDATA;
  logic [SW-1:0] PSTRB;
  logic [DW-1:0] PRDATA;
  logic          PREADY, PSLVERR;
  logic [1:0]    dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [DW:0] exp_q[$];

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    int            waits;
    logic [DW-1:0] prdata;
    logic          slverr;
    int            hold;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
  } vec_t;

  vec_t vecs[6];

  apb_master_bridge #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_strb    (cmd_strb),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .PADDR       (PADDR),
    .PWRITE      (PWRITE),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PWDATA      (PWDATA),
    .PSTRB       (PSTRB),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 PCLK = ~PCLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s got=timeout expected=event at %0t", name, $time);
  endtask

  // Reference: reads return slave data, writes return zero; error mirrors PSLVERR.
  function automatic logic [DW:0] model_rsp(input vec_t v);
    logic [DW-1:0] d;
    d = v.write ? '0 : v.prdata;
    return {v.slverr, d};
  endfunction

  function automatic vec_t mk(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                              input logic [SW-1:0] st, input int w, input logic [DW-1:0] prd,
                              input logic se, input int h, input logic [DW-1:0] er, input logic ee);
    vec_t v;
    v.write = wr; v.addr = a; v.wdata = wd; v.strb = st; v.waits = w;
    v.prdata = prd; v.slverr = se; v.hold = h; v.exp_rdata = er; v.exp_err = ee;
    return v;
  endfunction

  task automatic slave_idle_junk();
    PREADY  = 1'($urandom);
    PRDATA  = $urandom;
    PSLVERR = 1'($urandom);
  endtask

  // ---------------- driver: one full transfer with protocol checks ----------------
  // Called at a negedge. Leaves time at the negedge after the response handshake.
  task automatic run_xfer(input vec_t v, input logic [DW:0] exp_rsp);
    int lat, pen, sel, guard;
    logic [DW-1:0] exp_pwdata;
    logic [SW-1:0] exp_pstrb;
    logic [DW:0]   exp_now;
    exp_pwdata = v.write ? v.wdata : '0;
    exp_pstrb  = v.write ? v.strb : '0;
    exp_q.push_back(exp_rsp);
    cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr;
    cmd_wdata = v.wdata; cmd_strb = v.strb; rsp_ready = 1'b0;
    guard = 0;
    while (!cmd_ready && guard < 20) begin
      @(negedge PCLK);
      guard++;
    end
    if (!cmd_ready) begin
      fail_now("cmd_accept");
      cmd_valid = 1'b0;
      exp_now = exp_q.pop_back();
      return;
    end
    @(posedge PCLK);
    lat = 0; pen = 0; sel = 0;
    while (lat < 64) begin
      @(negedge PCLK);
      lat++;
      if (lat == 1) begin
        cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = $urandom;
        cmd_wdata = $urandom; cmd_strb = SW'($urandom);
      end
      if (rsp_valid) break;
      if (PSEL) sel++;
      chk("cmd_ready_busy", cmd_ready, 1'b0);
      if (PENABLE) begin
        pen++;
        chk("access_psel", PSEL, 1'b1);
        chk("access_paddr", PADDR, v.addr);
        chk("access_pwrite", PWRITE, v.write);
        chk("access_pwdata", PWDATA, exp_pwdata);
        chk("access_pstrb", PSTRB, exp_pstrb);
        if (pen == v.waits + 1) begin
          PREADY = 1'b1; PRDATA = v.prdata; PSLVERR = v.slverr;
        end else begin
          PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'($urandom);
        end
      end else begin
        if (lat == 1) begin
          chk("setup_psel", PSEL, 1'b1);
          chk("setup_paddr", PADDR, v.addr);
          chk("setup_pwrite", PWRITE, v.write);
          chk("setup_pwdata", PWDATA, exp_pwdata);
          chk("setup_pstrb", PSTRB, exp_pstrb);
        end
        slave_idle_junk();
      end
    end
    slave_idle_junk();
    chk("rsp_latency", lat, v.waits + 3);
    chk("penable_cycles", pen, v.waits + 1);
    chk("psel_cycles", sel, v.waits + 2);
    chk("done_psel", PSEL, 1'b0);
    chk("done_penable", PENABLE, 1'b0);
    chk("rsp_valid", rsp_valid, 1'b1);
    exp_now = exp_q.pop_front();
    chk("rsp_rdata", rsp_rdata, exp_now[DW-1:0]);
    chk("rsp_err", rsp_err, exp_now[DW]);
    for (int h = 0; h < v.hold; h++) begin
      cmd_valid = 1'b1;
      @(negedge PCLK);
      slave_idle_junk();
      chk("hold_rsp_valid", rsp_valid, 1'b1);
      chk("hold_rsp_rdata", rsp_rdata, exp_now[DW-1:0]);
      chk("hold_rsp_err", rsp_err, exp_now[DW]);
      chk("hold_cmd_ready", cmd_ready, 1'b0);
      chk("hold_psel", PSEL, 1'b0);
    end
    rsp_ready = 1'b1;
    @(negedge PCLK);
    rsp_ready = 1'b0;
    chk("rsp_cleared", rsp_valid, 1'b0);
    chk("cmd_ready_after_rsp", cmd_ready, 1'b1);
    chk("paddr_kept", PADDR, v.addr);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat, pen;
    vec_t rv;

    vecs[0] = mk(1'b1, 32'h1, 32'h1, 4'b0001, 0, 32'hDEAD_BEEF, 1'b0, 0, 32'h0, 1'b0);
    vecs[1] = mk(1'b0, 32'h1, 32'hFFFF_FFFF, 4'b1111, 3, 32'h101, 1'b0, 0, 32'h101, 1'b0);
    vecs[2] = mk(1'b1, 32'h3, 32'hCAFE_0003, 4'b1100, 0, 32'h1234, 1'b1, 0, 32'h0, 1'b1);
    vecs[3] = mk(1'b0, 32'h2, 32'h0, 4'b0000, 0, 32'hA5A5_5A5A, 1'b0, 0, 32'hA5A5_5A5A, 1'b0);
    vecs[4] = mk(1'b0, 32'h10, 32'h0, 4'b0000, 1, 32'h1234_5678, 1'b0, 5, 32'h1234_5678, 1'b0);
    vecs[5] = mk(1'b1, 32'hFFFF_FFFC, 32'h8765_4321, 4'b1111, 2, 32'h0BAD, 1'b1, 0, 32'h0, 1'b1);

    PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_strb = '0; rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    repeat (3) @(negedge PCLK);

    // Reset state
    chk("rst_psel", PSEL, 1'b0);
    chk("rst_penable", PENABLE, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_paddr", PADDR, 32'h0);
    chk("rst_pwrite", PWRITE, 1'b0);
    chk("rst_pwdata", PWDATA, 32'h0);
    chk("rst_pstrb", PSTRB, 4'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_state", dbg_state, 2'd0);
    PRESETn = 1'b1;
    @(negedge PCLK);
    chk("post_rst_cmd_ready", cmd_ready, 1'b1);

    // Directed table
    for (int i = 0; i < 6; i++) begin
      run_xfer(vecs[i], {vecs[i].exp_err, vecs[i].exp_rdata});
    end
    cmd_valid = 1'b0;

    // Reset pulsed during ACCESS
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40; cmd_strb = 4'hF; rsp_ready = 1'b0;
    PREADY = 1'b0;
    @(posedge PCLK);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    PREADY = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    chk("rstmid_in_access", PENABLE, 1'b1);
    #2;
    PRESETn = 1'b0;
    #1;
    chk("rstmid_psel", PSEL, 1'b0);
    chk("rstmid_penable", PENABLE, 1'b0);
    chk("rstmid_rsp_valid", rsp_valid, 1'b0);
    chk("rstmid_cmd_ready", cmd_ready, 1'b0);
    @(negedge PCLK);
    PREADY = 1'b1; PRDATA = 32'h7777; PSLVERR = 1'b1;
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    chk("rstmid_release_cmd_ready", cmd_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge PCLK);
      chk("rstmid_no_stale_rsp", rsp_valid, 1'b0);
      chk("rstmid_no_psel", PSEL, 1'b0);
    end
    PREADY = 1'b0;

    // Randomized stream against the reference model
    for (int i = 0; i < 40; i++) begin
      rv.write  = 1'($urandom);
      rv.addr   = $urandom;
      rv.wdata  = $urandom;
      rv.strb   = SW'($urandom);
      rv.waits  = $urandom_range(0, 4);
      rv.prdata = $urandom;
      rv.slverr = ($urandom_range(0, 3) == 0);
      rv.hold   = $urandom_range(0, 3);
      rv.exp_rdata = '0;
      rv.exp_err   = 1'b0;
      run_xfer(rv, model_rsp(rv));
    end
    cmd_valid = 1'b0;

    // Slave that never answers
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h80; rsp_ready = 1'b0; PREADY = 1'b0;
    @(posedge PCLK);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    lat = 0; pen = 0;
    while (lat < 300) begin
      if (rsp_valid) break;
      if (PENABLE) pen++;
      PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'($urandom);
      @(negedge PCLK);
      lat++;
    end
`ifdef APB_MASTER_TIMEOUT_EN
    chk("timeout_access_cycles", pen, 8);
    chk("timeout_rsp_valid", rsp_valid, 1'b1);
    chk("timeout_rsp_err", rsp_err, 1'b1);
    chk("timeout_rsp_rdata", rsp_rdata, 32'h0);
    chk("timeout_psel", PSEL, 1'b0);
    chk("timeout_penable", PENABLE, 1'b0);
    rsp_ready = 1'b1;
    @(negedge PCLK);
    rsp_ready = 1'b0;
    chk("timeout_rsp_cleared", rsp_valid, 1'b0);
`else
    chk("wait_access_cycles", pen, 299);
    chk("wait_rsp_valid", rsp_valid, 1'b0);
    chk("wait_psel", PSEL, 1'b1);
    chk("wait_penable", PENABLE, 1'b1);
    chk("wait_paddr", PADDR, 32'h80);
    PREADY = 1'b1; PRDATA = 32'h55AA; PSLVERR = 1'b0;
    @(negedge PCLK);
    PREADY = 1'b0;
    chk("late_rsp_valid", rsp_valid, 1'b1);
    chk("late_rsp_rdata", rsp_rdata, 32'h55AA);
    chk("late_rsp_err", rsp_err, 1'b0);
    rsp_ready = 1'b1;
    @(negedge PCLK);
    rsp_ready = 1'b0;
    chk("late_rsp_cleared", rsp_valid, 1'b0);
`endif
    @(negedge PCLK);
    chk("end_cmd_ready", cmd_ready, 1'b1);
    chk("end_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
